// File: rtl/tri_bbox_unit.sv
// tri_bbox_unit: sequential, handshaked triangle bounding-box engine.
// Latches one triangle, folds min/max over the vertices one per cycle,
// rounds extents half-up to the pixel grid and holds the box until taken.
// Define BBOX_CLIP_EN to clamp to the screen and flag off-screen triangles;
// without it the rounded extents pass straight through and out_empty is 0.

// Per-axis accumulator, rounding and optional screen limit.
module tri_bbox_axis #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 6,
  parameter bit CLIP  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             fold,
  input  logic [1:0]       idx,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] rmin,
  output logic [WIDTH-1:0] rmax,
  output logic             off
);
  logic [WIDTH-1:0] c1_q, c2_q, mn, mx, vi, rx;

  // Round half-up to whole pixels; saturate to the top pixel on overflow.
  function automatic logic [WIDTH-1:0] rnd(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v[WIDTH-1:FRAC], {FRAC{1'b0}}} + ((WIDTH+1)'(v[FRAC-1]) << FRAC);
    return s[WIDTH] ? {{(WIDTH-FRAC){1'b1}}, {FRAC{1'b0}}} : s[WIDTH-1:0];
  endfunction

  assign vi = (idx == 2'd1) ? c1_q : c2_q;

  // Vertex 0 seeds the accumulators directly; v1/v2 are held for the scan.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c1_q <= '0;
      c2_q <= '0;
      mn   <= '0;
      mx   <= '0;
    end else if (load) begin
      c1_q <= c1;
      c2_q <= c2;
      mn   <= c0;
      mx   <= c0;
    end else if (fold) begin
      if (vi < mn) mn <= vi;
      if (vi > mx) mx <= vi;
    end
  end

  // Rounded extents, clamped to the screen limit when clipping is built in.
  always_comb begin
    rmin = rnd(mn);
    rx   = rnd(mx);
    rmax = (CLIP && (rx > lim)) ? lim : rx;
    off  = CLIP && (rmin > lim);
  end
endmodule

module tri_bbox_unit #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] v0x,
  input  logic [WIDTH-1:0] v1x,
  input  logic [WIDTH-1:0] v2x,
  input  logic [WIDTH-1:0] v0y,
  input  logic [WIDTH-1:0] v1y,
  input  logic [WIDTH-1:0] v2y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] XMIN,
  output logic [WIDTH-1:0] XMAX,
  output logic [WIDTH-1:0] YMIN,
  output logic [WIDTH-1:0] YMAX,
  output logic             out_empty
);
`ifdef BBOX_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif
  localparam logic [WIDTH-1:0] XLIM = WIDTH'((SCREEN_W - 1) << FRAC);
  localparam logic [WIDTH-1:0] YLIM = WIDTH'((SCREEN_H - 1) << FRAC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] state, idx;
  logic       load, fold, empty;
  logic [1:0][WIDTH-1:0] c0, c1, c2, lim, rmin, rmax;
  logic [1:0]            off;

  // Axis 0 is X, axis 1 is Y.
  assign c0  = {v0y, v0x};
  assign c1  = {v1y, v1x};
  assign c2  = {v2y, v2x};
  assign lim = {YLIM, XLIM};

  assign in_ready = (state == S_IDLE);
  assign load     = in_ready && in_valid;
  assign fold     = (state == S_SCAN);
  assign empty    = |off;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    tri_bbox_axis #(.WIDTH(WIDTH), .FRAC(FRAC), .CLIP(CLIP_ON)) u_axis (
      .CLK  (CLK),
      .RST_N(RST_N),
      .load (load),
      .fold (fold),
      .idx  (idx),
      .c0   (c0[a]),
      .c1   (c1[a]),
      .c2   (c2[a]),
      .lim  (lim[a]),
      .rmin (rmin[a]),
      .rmax (rmax[a]),
      .off  (off[a])
    );
  end

  // Control FSM and output registers; outputs only change in FINAL.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      out_valid <= 1'b0;
      out_empty <= 1'b0;
      XMIN      <= '0;
      XMAX      <= '0;
      YMIN      <= '0;
      YMAX      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state <= S_SCAN;
          idx   <= 2'd1;
        end
        S_SCAN: if (idx == 2'd2) begin
          state <= S_FINAL;
          idx   <= 2'd0;
        end else begin
          idx <= idx + 2'd1;
        end
        S_FINAL: begin
          XMIN      <= empty ? '0 : rmin[0];
          XMAX      <= empty ? '0 : rmax[0];
          YMIN      <= empty ? '0 : rmin[1];
          YMAX      <= empty ? '0 : rmax[1];
          out_empty <= empty;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/tri_bbox_unit.md
# tri_bbox_unit

- Sequential, handshaked, parametrised bounding-box engine for the rasteriser front end.
- Accepts one triangle (three fixed-point vertices) per transaction and folds min/max over the vertices one per cycle.
- Rounds the extents to the pixel grid, optionally clips them to the screen, and holds the result until the downstream edge-walker takes it.
- Sits between vertex setup and the edge-function/scan stage. It replaces the free-running, count-sampled combinational min/max.

## Interface
Parameters:
- WIDTH, 16, bit width of every coordinate (unsigned fixed point)
- FRAC, 6, number of fractional bits within WIDTH
- SCREEN_W, 640, screen width in pixels; (SCREEN_W-1)<<FRAC must fit in WIDTH
- SCREEN_H, 480, screen height in pixels; same fit rule

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  triangle present on vertex inputs
- in_ready  out  1  block can accept a triangle
- v0x, v1x, v2x  in  WIDTH each  vertex X coordinates
- v0y, v1y, v2y  in  WIDTH each  vertex Y coordinates
- out_valid  out  1  bounding box valid
- out_ready  in  1  downstream accepts bounding box
- XMIN, XMAX, YMIN, YMAX  out  WIDTH each  rounded (and clipped) extents, same fixed-point format as inputs
- out_empty  out  1  triangle lies entirely off-screen; valid with out_valid

## Operation
- FSM states are IDLE, SCAN, FINAL and HOLD. A 2-bit vertex index counts within SCAN.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch all six coordinates;
  - load vertex 0 into the x/y min/max accumulators;
  - set index=1 and go to SCAN.
- SCAN: in_ready=0. Each cycle, fold vertex[index] into the accumulators with unsigned compares. Ties keep either value, since the value is identical. After index=2, go to FINAL.
- FINAL: register the rounded and clipped results and out_empty into the outputs, set out_valid=1 and go to HOLD.
- HOLD: outputs are stable. On out_valid&&out_ready, clear out_valid and return to IDLE.
- Rounding is round-half-up to an integer pixel: r(v) = {v[WIDTH-1:FRAC], FRAC'b0} + (v[FRAC-1] << FRAC).
  - If the addition overflows WIDTH, saturate to {all ones, FRAC'b0}.
- Clipping (see Configuration), with XLIM=(SCREEN_W-1)<<FRAC and YLIM=(SCREEN_H-1)<<FRAC:
  - XMAX=min(r(xmax), XLIM) and YMAX=min(r(ymax), YLIM).
  - The lower bound of 0 is implicit (unsigned).
  - If r(xmin)>XLIM or r(ymin)>YLIM, then out_empty=1 and all four extents are forced to 0.
- Vertex inputs are ignored outside the accepting edge. Changing them mid-scan has no effect.

## Timing
- Reset (asynchronous, any state): state=IDLE, index=0, in_ready=1 after release, out_valid=0, out_empty=0, XMIN=XMAX=YMIN=YMAX=0. Accumulators clear and any partial triangle is discarded.
- Accept on edge E0. SCAN folds happen on E1 (v1) and E2 (v2). Outputs and out_valid=1 register on E3. Latency is 3 edges from acceptance to out_valid.
- out_valid stays high and outputs stay constant until the out_ready handshake edge Ek. After Ek, out_valid=0.
- in_ready is high only in IDLE. The earliest re-accept is the edge after Ek. Peak throughput is one triangle per 5 cycles with out_ready tied high.
- in_ready does not depend combinationally on out_ready, and there is no combinational path from the in_* inputs to the out_* outputs.

## Configuration
- Macro BBOX_CLIP_EN.
- When defined: screen clamping and off-screen detection are active as described above.
- When undefined: the rounded extents pass through unclipped, SCREEN_W/SCREEN_H are unused, and out_empty is tied to 0. Timing is unchanged.

## Test plan
All scenarios use WIDTH=16, FRAC=6 and default screen parameters unless noted.
- Basic round: x = 96, 640, 330 and y = 64, 1000, 31 -> after 3 edges out_valid=1 with XMIN=128, XMAX=640, YMIN=0, YMAX=1024, out_empty=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles -> outputs stable, out_valid=1, in_ready=0, a new in_valid is not accepted.
  - Then raise out_ready -> handshake occurs and in_ready returns the next cycle.
- Clip (BBOX_CLIP_EN): x = 100, 45000, 200 and y = 0, 64, 40000 -> XMAX=40896, YMAX=30656, XMIN=128, YMIN=0, out_empty=0.
- Off-screen (BBOX_CLIP_EN): all x = 41000 and y = 10 -> out_empty=1, all extents 0.
- Saturation (BBOX_CLIP_EN undefined): x = 0xFFE0, 0, 0 -> XMAX=0xFFC0 and out_empty=0.
- Reset mid-scan: assert RST_N=0 during SCAN -> outputs go to 0 and out_valid=0 immediately. After release, in_ready=1 and the next triangle produces correct results with no stale extents.
